scdaq_rdo_master: RTL and testbench

Readout initiator for the SCDAQ sample buffer. On a Start pulse it drives the RDO request/acknowledge handshake to fetch NREAD samples from consecutive buffer addresses 0..NREAD-1, then asserts RDO_Done to release the buffer. Each fetched sample goes out on a ready/valid stream to the downstream consumer (display/host link). The block sits on the RDO_Clock domain, opposite the SCDAQ readout port.

---
 rtl/scdaq_rdo_master.sv | 154 +++++++++++++++
 tb/tb_scdaq_rdo_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scdaq_rdo_master.sv
// scdaq_rdo_master: readout initiator for the SCDAQ sample buffer.
// Walks buffer addresses 0..NREAD-1 over the RDO req/ack handshake,
// forwards each sample on a ready/valid stream and strobes RDO_Done at the end.
`timescale 1ns/1ps
module scdaq_rdo_master #(
  parameter int NSAMPLES     = 128,
  parameter int PRECISION    = 14,
  parameter int RDO_ADD_BLEN = 7,
  parameter int NREAD        = 64,
  parameter int TIMEOUT      = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic [RDO_ADD_BLEN:0]   o_rdo_add,
  output logic                    o_rdo_req,
  input  logic                    i_rdo_ack,
  input  logic [PRECISION-1:0]    i_rdo_q,
  output logic                    o_rdo_done,
  output logic [PRECISION-1:0]    o_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_last,
  output logic                    o_timeout_err
);

  localparam int AW    = RDO_ADD_BLEN + 1;
  // Never read past the attached buffer, even if NREAD is misconfigured.
  localparam int NLAST = ((NREAD > NSAMPLES) ? NSAMPLES : NREAD) - 1;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] ADDR_LAST = AW'(NLAST);
  // Counter holds the number of REQ cycles already spent without Ack.
  localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         w_addr_nxt;
  logic [TW-1:0]         r_tcnt;
  logic [TW-1:0]         w_tcnt_nxt;
  logic [PRECISION-1:0]  r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  w_capture;
  logic                  w_timeout;
  logic                  w_out_free;
  logic                  w_at_last;

  assign w_at_last  = (r_addr == ADDR_LAST);
  // Output register can take a new sample if empty or being drained this cycle.
  assign w_out_free = !r_out_valid || i_out_ready;

  assign o_busy        = (r_state != S_IDLE);
  assign o_rdo_req     = (r_state == S_REQ);
  assign o_rdo_done    = (r_state == S_DONE);
  assign o_rdo_add     = r_addr;
  assign o_timeout_err = w_timeout;
  assign o_out_data    = r_out_data;
  assign o_out_valid   = r_out_valid;
  assign o_out_last    = r_out_last;

  // Next-state, address and timeout-counter decisions for the handshake FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_tcnt_nxt  = r_tcnt;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_addr_nxt  = '0;
          w_tcnt_nxt  = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_rdo_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
          if ((TIMEOUT != 0) && (r_tcnt == TCNT_LAST)) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RELEASE: begin
        // Wait for the responder to drop Ack before issuing the next request.
        if (!i_rdo_ack && w_out_free) begin
          if (w_at_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + AW'(1);
            w_tcnt_nxt  = '0;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address and timeout counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_tcnt <= '0;
    end else begin
      r_addr <= w_addr_nxt;
      r_tcnt <= w_tcnt_nxt;
    end
  end

  // Output stream register: a new capture wins over a same-cycle drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_rdo_q;
      r_out_last  <= w_at_last;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scdaq_rdo_master.sv
// Testbench for scdaq_rdo_master: SCDAQ responder model, scoreboard of
// expected samples pushed at Ack time and popped on each stream handshake.
`timescale 1ns/1ps
module tb_scdaq_rdo_master;

  localparam int NSAMPLES     = 128;
  localparam int PRECISION    = 14;
  localparam int RDO_ADD_BLEN = 7;
  localparam int NREAD        = 64;
  localparam int TIMEOUT      = 255;
  localparam int AW           = RDO_ADD_BLEN + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 rdo_ack = 1'b0;
  logic [PRECISION-1:0] rdo_q = '0;
  logic                 out_ready = 1'b0;

  logic                 o_busy;
  logic [AW-1:0]        o_rdo_add;
  logic                 o_rdo_req;
  logic                 o_rdo_done;
  logic [PRECISION-1:0] o_out_data;
  logic                 o_out_valid;
  logic                 o_out_last;
  logic                 o_timeout_err;

  scdaq_rdo_master #(
    .NSAMPLES(NSAMPLES), .PRECISION(PRECISION), .RDO_ADD_BLEN(RDO_ADD_BLEN),
    .NREAD(NREAD), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(o_busy), .o_rdo_add(o_rdo_add), .o_rdo_req(o_rdo_req),
    .i_rdo_ack(rdo_ack), .i_rdo_q(rdo_q), .o_rdo_done(o_rdo_done),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_out_last(o_out_last), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PRECISION-1:0] d;
    logic                 l;
  } exp_t;

  exp_t exp_q[$];
  exp_t new_e;
  exp_t got;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  int terr_cnt = 0;
  int p0, l0, d0, t0;

  // Responder configuration
  int ack_delay_cfg = 0;
  int hold_cfg      = 0;
  int no_ack_addr   = -1;
  bit rnd_mode      = 1'b0;
  bit rnd_ready     = 1'b0;
  int wcnt = 0, hcnt = 0, cur_delay = 0, cur_hold = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SCDAQ responder: acks after a delay, holds Ack after Req falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      rdo_ack = 1'b0;
      wcnt = 0;
      hcnt = 0;
    end else if (rdo_ack) begin
      if (!o_rdo_req) begin
        if (hcnt >= cur_hold) rdo_ack = 1'b0;
        else hcnt++;
      end
    end else if (o_rdo_req && (int'(o_rdo_add) != no_ack_addr)) begin
      if (wcnt >= cur_delay) begin
        rdo_q   = rnd_mode ? PRECISION'($urandom) : PRECISION'(int'(o_rdo_add) + 100);
        rdo_ack = 1'b1;
        new_e.d = rdo_q;
        new_e.l = (int'(o_rdo_add) == NREAD - 1);
        exp_q.push_back(new_e);
        wcnt = 0;
        hcnt = 0;
        cur_delay = rnd_mode ? int'($urandom_range(0, 3)) : ack_delay_cfg;
        cur_hold  = rnd_mode ? int'($urandom_range(0, 2)) : hold_cfg;
      end else begin
        wcnt++;
      end
    end
  end

  // Random consumer backpressure
  always @(negedge clk) begin
    if (rnd_ready) out_ready = ($urandom_range(0, 99) < 60);
  end

  // Monitor: scoreboard pops plus protocol invariants.
  logic          prev_req = 0, prev_ack = 0, prev_done = 0, prev_terr = 0, prev_stall = 0;
  logic [AW-1:0] prev_add = '0;
  logic [PRECISION-1:0] prev_data = '0;
  int            req_run = 0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_req = 0; prev_ack = 0; prev_done = 0; prev_terr = 0; prev_stall = 0;
      prev_add = '0; prev_data = '0; req_run = 0;
    end else begin
      chk("add_range", (int'(o_rdo_add) <= NREAD - 1), 1);
      if (o_rdo_req && prev_req) chk("add_stable", o_rdo_add, prev_add);
      if (o_rdo_req && !prev_req) chk("req_after_ack_low", prev_ack, 0);
      if (o_rdo_req) req_run = (prev_req && o_rdo_add == prev_add) ? req_run + 1 : 1;
      else req_run = 0;
      if (o_timeout_err) begin
        terr_cnt++;
        chk("timeout_len", req_run, TIMEOUT);
      end
      if (prev_terr) chk("done_after_terr", o_rdo_done, 1);
      if (o_rdo_done) begin
        done_cnt++;
        chk("done_single", prev_done, 0);
        if (!prev_terr) chk("done_drained", o_out_valid, 0);
      end
      if (prev_done) chk("busy_after_done", o_busy, 0);
      if (o_out_valid && prev_stall) chk("hold_data", o_out_data, prev_data);
      if (o_out_valid && out_ready) begin
        chk("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("data", o_out_data, got.d);
          chk("last", o_out_last, got.l);
          pop_cnt++;
          if (o_out_last) last_cnt++;
        end
      end
      prev_req   = o_rdo_req;
      prev_ack   = rdo_ack;
      prev_add   = o_rdo_add;
      prev_done  = o_rdo_done;
      prev_terr  = o_timeout_err;
      prev_stall = o_out_valid && !out_ready;
      prev_data  = o_out_data;
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_req"}, o_rdo_req, 0);
    chk({nm, "_done"}, o_rdo_done, 0);
    chk({nm, "_valid"}, o_out_valid, 0);
    chk({nm, "_last"}, o_out_last, 0);
    chk({nm, "_terr"}, o_timeout_err, 0);
    chk({nm, "_add"}, o_rdo_add, 0);
    chk({nm, "_data"}, o_out_data, 0);
  endtask

  task automatic start_rd(input string nm);
    p0 = pop_cnt; l0 = last_cnt; d0 = done_cnt; t0 = terr_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_req_after_start"}, o_rdo_req, 1);
    chk({nm, "_add_after_start"}, o_rdo_add, 0);
  endtask

  task automatic wait_done(input string nm, input int budget, input bit start_in_done);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_rdo_done) begin
        seen = 1'b1;
        if (start_in_done) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    chk({nm, "_done_seen"}, seen, 1);
  endtask

  task automatic finish_rd(input string nm, input int pops, input int lasts, input int terrs);
    repeat (4) @(negedge clk);
    chk({nm, "_pops"}, pop_cnt - p0, pops);
    chk({nm, "_lasts"}, last_cnt - l0, lasts);
    chk({nm, "_dones"}, done_cnt - d0, 1);
    chk({nm, "_terrs"}, terr_cnt - t0, terrs);
    chk({nm, "_busy_idle"}, o_busy, 0);
    chk({nm, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    int dsnap;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic readout, ack one cycle after Req, consumer always ready
    out_ready = 1'b1;
    ack_delay_cfg = 0; hold_cfg = 0; cur_delay = 0; cur_hold = 0;
    start_rd("basic");
    wait_done("basic", 3000, 1'b0);
    finish_rd("basic", NREAD, 1, 0);

    // Backpressure on sample 5
    start_rd("bp");
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (o_out_valid && o_out_data == PRECISION'(105)) found = 1'b1;
    end
    chk("bp_found", found, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", o_out_data, 105);
      chk("bp_valid", o_out_valid, 1);
      chk("bp_req", o_rdo_req, 0);
      chk("bp_add", o_rdo_add, 5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done("bp", 3000, 1'b0);
    finish_rd("bp", NREAD, 1, 0);

    // Responder holds Ack 3 cycles after Req falls
    hold_cfg = 3; cur_hold = 3;
    start_rd("hold");
    wait_done("hold", 5000, 1'b0);
    finish_rd("hold", NREAD, 1, 0);
    hold_cfg = 0; cur_hold = 0;

    // Randomized delays, holds, data and backpressure
    rnd_mode = 1'b1; rnd_ready = 1'b1; cur_delay = 2;
    for (int r = 0; r < 2; r++) begin
      start_rd("rnd");
      wait_done("rnd", 8000, 1'b0);
      finish_rd("rnd", NREAD, 1, 0);
    end
    rnd_mode = 1'b0; rnd_ready = 1'b0; out_ready = 1'b1;
    cur_delay = 0; cur_hold = 0;

    // Address 7 never acknowledged
    no_ack_addr = 7;
    start_rd("tmo");
    wait_done("tmo", 3000, 1'b0);
    finish_rd("tmo", 7, 0, 1);
    no_ack_addr = -1;

    // Start while busy and during DONE
    start_rd("ign");
    repeat (20) @(negedge clk);
    chk("ign_busy_mid", o_busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 3000, 1'b1);
    finish_rd("ign", NREAD, 1, 0);

    // Reset mid-readout at address 20
    start_rd("mrst");
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (o_rdo_req && o_rdo_add == AW'(20)) found = 1'b1;
    end
    chk("mrst_found", found, 1);
    dsnap = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mrst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_no_done", done_cnt, dsnap);
    chk("mrst_idle", o_busy, 0);
    start_rd("post");
    wait_done("post", 3000, 1'b0);
    finish_rd("post", NREAD, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
